// File: rtl/button_debouncer.sv
// Debounces a bouncy button/switch into a clean level plus a one-cycle sample strobe.
// Define DEBOUNCER_SYNC_EN to pass raw through a 2-flop synchronizer (adds 2 cycles latency).
module button_debouncer #(
    parameter int CLK_DIV      = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic update,
    output logic busy
);

    // state  | meaning
    // S_LOW  | stable low
    // W_HIGH | low, qualifying a rise
    // S_HIGH | stable high
    // W_LOW  | high, qualifying a fall
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        W_HIGH = 2'd1,
        S_HIGH = 2'd2,
        W_LOW  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  CNT_TGT  = 8'(STABLE_COUNT);

    logic [15:0] pre;
    logic        sample;
    logic        s;
    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next, cnt_inc;
    logic        level_next, busy_next;

    assign sample  = (pre == DIV_LAST);
    assign cnt_inc = cnt + 8'd1;

`ifdef DEBOUNCER_SYNC_EN
    logic sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= 16'd0;
            update <= 1'b0;
            state  <= S_LOW;
            cnt    <= 8'd0;
            level  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            pre    <= sample ? 16'd0 : pre + 16'd1;
            update <= sample;
            state  <= state_next;
            cnt    <= cnt_next;
            level  <= level_next;
            busy   <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (sample) begin
            case (state)
                S_LOW: begin
                    if (s) begin
                        if (CNT_TGT == 8'd1) begin
                            state_next = S_HIGH;
                            cnt_next   = 8'd0;
                        end else begin
                            state_next = W_HIGH;
                            cnt_next   = 8'd1;
                        end
                    end
                end
                W_HIGH: begin
                    if (!s) begin
                        state_next = S_LOW;
                        cnt_next   = 8'd0;
                    end else if (cnt_inc >= CNT_TGT) begin
                        state_next = S_HIGH;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        if (CNT_TGT == 8'd1) begin
                            state_next = S_LOW;
                            cnt_next   = 8'd0;
                        end else begin
                            state_next = W_LOW;
                            cnt_next   = 8'd1;
                        end
                    end
                end
                W_LOW: begin
                    if (s) begin
                        state_next = S_HIGH;
                        cnt_next   = 8'd0;
                    end else if (cnt_inc >= CNT_TGT) begin
                        state_next = S_LOW;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = S_LOW;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so level flips on the update edge.
    always_comb begin
        level_next = (state_next == S_HIGH) || (state_next == W_LOW);
        busy_next  = (state_next == W_HIGH) || (state_next == W_LOW);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: CLK_DIV=4 with STABLE_COUNT=3 and STABLE_COUNT=1 instances.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic raw, raw2;
    logic level, update, busy;
    logic level2, update2, busy2;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_l2;

    always #5 clk = ~clk;

    button_debouncer #(.CLK_DIV(4), .STABLE_COUNT(3)) dut (
        .clk(clk), .reset(reset), .raw(raw),
        .level(level), .update(update), .busy(busy)
    );

    button_debouncer #(.CLK_DIV(4), .STABLE_COUNT(1)) dut_fast (
        .clk(clk), .reset(reset), .raw(raw2),
        .level(level2), .update(update2), .busy(busy2)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_lvl(input string tag, input logic e_upd, input logic e_lvl, input logic e_busy);
        check({tag, ".update"}, update, e_upd);
        check({tag, ".level"},  level,  e_lvl);
        check({tag, ".busy"},   busy,   e_busy);
    endtask

    initial begin
        reset = 1'b1;
        raw   = 1'b0;
        raw2  = 1'b0;
        #1;
        check_lvl("reset", 1'b0, 1'b0, 1'b0);
        tick(2);
        check_lvl("reset_held", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Idle low: update every 4th cycle after release
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            check_lvl($sformatf("idle%0d", k), (k % 4 == 0), 1'b0, 1'b0);
        end
        check("idle.level2", level2, 1'b0);

        // Clean rise: three agreeing samples
        raw = 1'b1;
        tick(4);
        check_lvl("rise.s1", 1'b1, 1'b0, 1'b1);
        tick(4);
        check_lvl("rise.s2", 1'b1, 1'b0, 1'b1);
        tick(3);
        check_lvl("rise.pre3", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_lvl("rise.s3", 1'b1, 1'b1, 1'b0);

        // One-cycle low glitch between samples is ignored
        raw = 1'b0;
        tick(1);
        raw = 1'b1;
        check_lvl("glitch.mid", 1'b0, 1'b1, 1'b0);
        tick(3);
        check_lvl("glitch.s", 1'b1, 1'b1, 1'b0);
        tick(4);
        check_lvl("glitch.s2", 1'b1, 1'b1, 1'b0);

        // Clean fall
        raw = 1'b0;
        tick(4);
        check_lvl("fall.s1", 1'b1, 1'b1, 1'b1);
        tick(4);
        check_lvl("fall.s2", 1'b1, 1'b1, 1'b1);
        tick(4);
        check_lvl("fall.s3", 1'b1, 1'b0, 1'b0);

        // Bounce: high for two samples then low again
        raw = 1'b1;
        tick(4);
        check_lvl("bounce.s1", 1'b1, 1'b0, 1'b1);
        tick(4);
        check_lvl("bounce.s2", 1'b1, 1'b0, 1'b1);
        raw = 1'b0;
        tick(4);
        check_lvl("bounce.s3", 1'b1, 1'b0, 1'b0);
        tick(4);
        check_lvl("bounce.s4", 1'b1, 1'b0, 1'b0);

        // Async reset in W_HIGH with cnt=2, pending rise discarded
        raw = 1'b1;
        tick(8);
        check_lvl("pend.s2", 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check_lvl("async_rst", 1'b0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check_lvl("rel.c3", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_lvl("rel.s1", 1'b1, 1'b0, 1'b1);
        tick(4);
        check_lvl("rel.s2", 1'b1, 1'b0, 1'b1);
        tick(4);
        check_lvl("rel.s3", 1'b1, 1'b1, 1'b0);

        // STABLE_COUNT=1: raw rises one cycle before a sample
        tick(2);
        raw2 = 1'b1;
        tick(1);
        check("fast.pre.level", level2, 1'b0);
        check("fast.pre.update", update2, 1'b0);
        tick(1);
`ifdef DEBOUNCER_SYNC_EN
        exp_l2 = 1'b0;
`else
        exp_l2 = 1'b1;
`endif
        check("fast.s1.update", update2, 1'b1);
        check("fast.s1.level", level2, exp_l2);
        check("fast.s1.busy", busy2, 1'b0);
        tick(4);
        check("fast.s2.level", level2, 1'b1);
        check("fast.s2.busy", busy2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
